// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debouncer: channel FSM state codes
// and the width helpers used to size the tick prescaler and channel counters.
package key_pkg;

  // Channel FSM states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DEB_P   = 3'd1;
  localparam logic [2:0] ST_PRESSED = 3'd2;
  localparam logic [2:0] ST_LONG    = 3'd3;
  localparam logic [2:0] ST_DEB_R   = 3'd4;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a counter running 0..div-1 (at least one bit)
  function automatic int tick_width(input int div);
    return (clog2(div) < 1) ? 1 : clog2(div);
  endfunction

  // Width of a channel counter that must hold the largest of the three limits
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (clog2(m + 1) < 1) ? 1 : clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_tick_gen.sv
// Free-running prescaler shared by all key channels. Counts 0..TICK_DIV-1
// and flags the last count, so tick is high for exactly one clk per period.
module key_tick_gen
  import key_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int              TW   = tick_width(TICK_DIV);
  localparam logic [TW-1:0]   LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt;

  // Prescaler counter, wraps to zero after LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

  // Decoded from a flop, so the pulse is clean and lasts one cycle
  assign tick = (cnt == LAST);

endmodule

// File: rtl/multi_key_debouncer.sv
// N-channel push-button conditioner: per-key 2-flop sync, tick-based debounce,
// registered press/release pulses, long-press detect and auto-repeat.
// Outputs carry no handshake: each pulse output is high for exactly one clk
// and is to be consumed in that cycle; key_level is a plain registered level.
// Each channel's FSM state is visible as gen_ch[g].state for debug binding.
module multi_key_debouncer
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int DEB_TICKS    = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 100,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int            CW        = cnt_width(DEB_TICKS, LONG_TICKS, REPEAT_TICKS);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_TICKS - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = (REPEAT_TICKS == 0) ? '0 : CW'(REPEAT_TICKS - 1);
  localparam logic          REP_EN    = (REPEAT_TICKS != 0);
  // Raw pin level of a released key; also the reset value of the synchronisers
  localparam logic          IDLE_PIN  = (ACTIVE_LOW != 0);

  logic tick;

  key_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  for (genvar g = 0; g < N_KEYS; g++) begin : gen_ch
    logic [1:0]    sync_q;
    logic          s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          held;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          repeat_q;

    // Two-flop synchroniser; reset to the released level so reset never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {2{IDLE_PIN}};
      end else begin
        sync_q <= {sync_q[0], key_in[g]};
      end
    end

    // Polarity-normalised key: 1 = pressed
    assign s = sync_q[1] ^ IDLE_PIN;

    // Channel FSM: debounce, hold timer and repeat timer; s changes win over tick
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        held      <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (s) begin
              state <= ST_DEB_P;
              cnt   <= '0;
            end
          end
          ST_DEB_P: begin
            if (!s) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt == DEB_LAST) begin
                state   <= ST_PRESSED;
                press_q <= 1'b1;
                level_q <= 1'b1;
                cnt     <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          ST_PRESSED: begin
            if (!s) begin
              state <= ST_DEB_R;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt == LONG_LAST) begin
                state  <= ST_LONG;
                long_q <= 1'b1;
                held   <= 1'b1;
                cnt    <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          ST_LONG: begin
            if (!s) begin
              state <= ST_DEB_R;
              cnt   <= '0;
            end else if (tick && REP_EN) begin
              if (cnt == REP_LAST) begin
                repeat_q <= 1'b1;
                cnt      <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          ST_DEB_R: begin
            if (s) begin
              // Release was a glitch: resume, with the hold/repeat timer restarted
              state <= held ? ST_LONG : ST_PRESSED;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt == DEB_LAST) begin
                state     <= ST_IDLE;
                release_q <= 1'b1;
                level_q   <= 1'b0;
                held      <= 1'b0;
                cnt       <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            held  <= 1'b0;
          end
        endcase
      end
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = long_q;
    assign key_repeat[g]  = repeat_q;
  end

endmodule
